column_block_packer: RTL and testbench

//   Inverse of the key/state column splitter. Collects NCOL column words arriving
//   one per handshake and packs them into one NCOL*COL_W block: 4 x 32b -> 128b.

---
 rtl/column_block_packer_if.sv | 40 ++++
 rtl/column_block_packer.sv | 124 ++++++++++++
 tb/tb_column_block_packer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/column_block_packer_if.sv
// -----------------------------------------------------------------------------
// column_block_packer_if
//   Handshake bundle between a column producer, the column_block_packer and a
//   block-wide consumer.
//   Signals:
//     in_col     COL_W       column word
//     in_sof     1           marks column 0 of a block
//     in_valid   1           in_col/in_sof valid
//     in_ready   1           packer accepts a column this cycle
//     out_block  COL_W*NCOL  packed block, column 0 in the MSBs
//     out_valid  1           out_block holds a complete block
//     out_ready  1           consumer takes out_block
//     err_resync 1           one-cycle framing error pulse
//   Modports:
//     master  producer/consumer side (drives in_* and out_ready)
//     slave   packer side
// -----------------------------------------------------------------------------
interface column_block_packer_if #(
  parameter int COL_W = 32,
  parameter int NCOL  = 4
);
  logic [COL_W-1:0]      in_col;
  logic                  in_sof;
  logic                  in_valid;
  logic                  in_ready;
  logic [COL_W*NCOL-1:0] out_block;
  logic                  out_valid;
  logic                  out_ready;
  logic                  err_resync;

  modport master (
    output in_col, in_sof, in_valid, out_ready,
    input  in_ready, out_block, out_valid, err_resync
  );

  modport slave (
    input  in_col, in_sof, in_valid, out_ready,
    output in_ready, out_block, out_valid, err_resync
  );
endinterface

// File: rtl/column_block_packer.sv
// -----------------------------------------------------------------------------
// column_block_packer
//   Collects NCOL column words (one per handshake) and packs them into a single
//   COL_W*NCOL block. Column 0 lands in the block MSBs. Partial blocks are kept
//   in a staging bank and never appear on out_block.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   column_block_packer_if.slave (column input, block output, error)
//   Parameters:
//     COL_W        width of one column word
//     NCOL         columns per block
//     REQUIRE_SOF  1: a block must start with in_sof; 0: in_sof only resyncs
// -----------------------------------------------------------------------------
module column_block_packer #(
  parameter int COL_W       = 32,
  parameter int NCOL        = 4,
  parameter bit REQUIRE_SOF = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  column_block_packer_if.slave   bus
);

  localparam int CNT_W = (NCOL > 1) ? $clog2(NCOL) : 1;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_col_cnt;
  // Only columns 0..NCOL-2 are staged; the last column goes straight into
  // out_block on the completing handshake.
  logic [COL_W-1:0]      r_staging [NCOL-1];
  logic [COL_W*NCOL-1:0] r_out_block;
  logic                  r_out_valid;
  logic                  r_err_resync;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_cnt_zero;
  logic                  w_cnt_last;
  logic                  w_resync;
  logic                  w_drop;
  logic                  w_complete;
  logic [COL_W*NCOL-1:0] w_block;

  // in_ready is the only decoded output; it must read 0 while reset is held.
  assign w_in_ready = rst & (r_state == ST_COLLECT);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_cnt_zero = (r_col_cnt == '0);
  assign w_cnt_last = (r_col_cnt == CNT_W'(NCOL - 1));
  // sof in the middle of a block restarts it with this column as column 0.
  assign w_resync   = w_accept & bus.in_sof & ~w_cnt_zero;
  // A non-sof column where a block should start is handshaken but discarded.
  assign w_drop     = w_accept & ~bus.in_sof & w_cnt_zero & REQUIRE_SOF;
  // Resync outranks completion, so a sof column never closes a block.
  assign w_complete = w_accept & w_cnt_last & ~w_resync & ~w_drop;

  // NOTE: every signal driven in an always_comb gets a default at the top, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_COLLECT: if (w_complete)    w_state_nxt = ST_HOLD;
      ST_HOLD:    if (bus.out_ready) w_state_nxt = ST_COLLECT;
      default:                       w_state_nxt = ST_COLLECT;
    endcase
  end

  always_comb begin
    w_block = '0;
    for (int k = 0; k < NCOL - 1; k++) begin
      w_block[(NCOL-k)*COL_W-1 -: COL_W] = r_staging[k];
    end
    w_block[COL_W-1:0] = bus.in_col;
  end

  // NOTE: sequential state is assigned with non-blocking <= only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_COLLECT;
      r_col_cnt    <= '0;
      r_out_block  <= '0;
      r_out_valid  <= 1'b0;
      r_err_resync <= 1'b0;
      // NOTE: the staging bank is a handful of flops, not a RAM, and a reset
      // must leave no trace of an abandoned block, so it is cleared here too.
      for (int k = 0; k < NCOL - 1; k++) begin
        r_staging[k] <= '0;
      end
    end else begin
      r_state      <= w_state_nxt;
      r_out_valid  <= (w_state_nxt == ST_HOLD);
      r_err_resync <= w_resync | w_drop;

      if (w_complete) begin
        r_out_block <= w_block;
      end

      if (w_resync) begin
        r_staging[0] <= bus.in_col;
        r_col_cnt    <= CNT_W'(1);
      end else if (w_accept && !w_drop) begin
        if (w_cnt_last) begin
          r_col_cnt <= '0;
        end else begin
          r_staging[r_col_cnt] <= bus.in_col;
          r_col_cnt            <= r_col_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_block  = r_out_block;
  assign bus.out_valid  = r_out_valid;
  assign bus.err_resync = r_err_resync;

endmodule

// File: tb/tb_column_block_packer.sv
// -----------------------------------------------------------------------------
// tb_column_block_packer
//   Directed bench for column_block_packer. Inputs change on the falling edge,
//   outputs are sampled on the falling edge after the rising edge that acted.
//   A second instance built with REQUIRE_SOF=0 covers the permissive framing.
// -----------------------------------------------------------------------------
module tb_column_block_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  column_block_packer_if #(.COL_W(32), .NCOL(4)) bus_a ();
  column_block_packer_if #(.COL_W(32), .NCOL(4)) bus_b ();

  column_block_packer #(.COL_W(32), .NCOL(4), .REQUIRE_SOF(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  column_block_packer #(.COL_W(32), .NCOL(4), .REQUIRE_SOF(1'b0)) u_dut_nosof (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic s, input logic [31:0] c, input logic o);
    bus_a.in_valid  = v;
    bus_a.in_sof    = s;
    bus_a.in_col    = c;
    bus_a.out_ready = o;
  endtask

  typedef struct {
    logic        valid;
    logic        sof;
    logic [31:0] col;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_val;
    logic        exp_err;
    logic [127:0] exp_blk;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic v, input logic s, input logic [31:0] c,
                              input logic o, input logic r, input logic val,
                              input logic e, input logic [127:0] b);
    vq.push_back('{v, s, c, o, r, val, e, b});
  endfunction

  localparam logic [127:0] B1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] B2 = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] B3 = 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD;
  localparam logic [127:0] B4 = 128'h01010101020202020303030304040404;
  localparam logic [127:0] B5 = 128'h08080808090909090A0A0A0A0B0B0B0B;
  localparam logic [127:0] BN = 128'hCAFEF00D112233445566778899AABBCC;
  localparam logic [127:0] BR = 128'hC0C0C0C0C1C1C1C1C2C2C2C2C3C3C3C3;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]  c2 [4];
    logic [31:0]  cn [4];
    logic [31:0]  c6 [12];
    logic [127:0] b6 [3];
    int idx, nblk, cyc, last_cyc;

    drive(1'b0, 1'b0, 32'h0, 1'b1);
    bus_b.in_valid  = 1'b0;
    bus_b.in_sof    = 1'b0;
    bus_b.in_col    = '0;
    bus_b.out_ready = 1'b1;

    // Reset state
    #12;
    check("reset_in_ready",  128'(bus_a.in_ready),   128'd0);
    check("reset_out_valid", 128'(bus_a.out_valid),  128'd0);
    check("reset_err",       128'(bus_a.err_resync), 128'd0);
    check("reset_block",     bus_a.out_block,        128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 128'(bus_a.in_ready), 128'd1);

    // Table: basic pack, mid-block resync, missing sof, sof without valid,
    // sof on the would-be last column.
    //  v  sof col           ordy  rdy val err block
    add(1, 1, 32'h2B7E1516, 1,    1,  0,  0,  128'd0);
    add(1, 0, 32'h28AED2A6, 1,    1,  0,  0,  128'd0);
    add(1, 0, 32'hABF71588, 1,    1,  0,  0,  128'd0);
    add(1, 0, 32'h09CF4F3C, 1,    0,  1,  0,  B1);
    add(0, 0, 32'h00000000, 1,    1,  0,  0,  B1);
    add(1, 1, 32'h11111111, 1,    1,  0,  0,  B1);
    add(1, 0, 32'h22222222, 1,    1,  0,  0,  B1);
    add(1, 1, 32'hAAAAAAAA, 1,    1,  0,  1,  B1);
    add(1, 0, 32'hBBBBBBBB, 1,    1,  0,  0,  B1);
    add(1, 0, 32'hCCCCCCCC, 1,    1,  0,  0,  B1);
    add(1, 0, 32'hDDDDDDDD, 1,    0,  1,  0,  B3);
    add(0, 0, 32'h00000000, 1,    1,  0,  0,  B3);
    add(1, 0, 32'h12345678, 1,    1,  0,  1,  B3);
    add(1, 1, 32'h01010101, 1,    1,  0,  0,  B3);
    add(0, 1, 32'hFFFFFFFF, 1,    1,  0,  0,  B3);
    add(1, 0, 32'h02020202, 1,    1,  0,  0,  B3);
    add(1, 0, 32'h03030303, 1,    1,  0,  0,  B3);
    add(1, 0, 32'h04040404, 1,    0,  1,  0,  B4);
    add(0, 0, 32'h00000000, 1,    1,  0,  0,  B4);
    add(1, 1, 32'h05050505, 1,    1,  0,  0,  B4);
    add(1, 0, 32'h06060606, 1,    1,  0,  0,  B4);
    add(1, 0, 32'h07070707, 1,    1,  0,  0,  B4);
    add(1, 1, 32'h08080808, 1,    1,  0,  1,  B4);
    add(1, 0, 32'h09090909, 1,    1,  0,  0,  B4);
    add(1, 0, 32'h0A0A0A0A, 1,    1,  0,  0,  B4);
    add(1, 0, 32'h0B0B0B0B, 1,    0,  1,  0,  B5);
    add(0, 0, 32'h00000000, 1,    1,  0,  0,  B5);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].valid, vq[i].sof, vq[i].col, vq[i].ordy);
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i),  128'(bus_a.in_ready),   128'(vq[i].exp_rdy));
      check($sformatf("vec%0d_out_valid", i), 128'(bus_a.out_valid),  128'(vq[i].exp_val));
      check($sformatf("vec%0d_err", i),       128'(bus_a.err_resync), 128'(vq[i].exp_err));
      check($sformatf("vec%0d_block", i),     bus_a.out_block,        vq[i].exp_blk);
    end

    // Backpressure: block held for 10 cycles, one stray in_valid during HOLD.
    c2 = '{32'h3243F6A8, 32'h885A308D, 32'h313198A2, 32'hE0370734};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, c2[i], 1'b0);
      @(negedge clk);
    end
    check("bp_valid_rise", 128'(bus_a.out_valid), 128'd1);
    check("bp_block",      bus_a.out_block,        B2);
    for (int i = 0; i < 10; i++) begin
      drive(i == 3, 1'b0, 32'hDEADBEEF, 1'b0);
      @(negedge clk);
      check("bp_hold_in_ready", 128'(bus_a.in_ready),  128'd0);
      check("bp_hold_valid",    128'(bus_a.out_valid), 128'd1);
      check("bp_hold_block",    bus_a.out_block,       B2);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("bp_release_in_ready", 128'(bus_a.in_ready),  128'd1);
    check("bp_release_valid",    128'(bus_a.out_valid), 128'd0);
    check("bp_release_block",    bus_a.out_block,       B2);

    // REQUIRE_SOF=0 instance: column without sof starts a block.
    cn = '{32'hCAFEF00D, 32'h11223344, 32'h55667788, 32'h99AABBCC};
    for (int i = 0; i < 4; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_sof   = 1'b0;
      bus_b.in_col   = cn[i];
      @(negedge clk);
      check("nosof_err", 128'(bus_b.err_resync), 128'd0);
    end
    bus_b.in_valid = 1'b0;
    check("nosof_valid", 128'(bus_b.out_valid), 128'd1);
    check("nosof_block", bus_b.out_block,       BN);

    // Async reset after two columns, asserted between clock edges.
    drive(1'b1, 1'b1, 32'hA0A0A0A0, 1'b1);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hB0B0B0B0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_block",    bus_a.out_block,        128'd0);
    check("rst_valid",    128'(bus_a.out_valid),  128'd0);
    check("rst_in_ready", 128'(bus_a.in_ready),   128'd0);
    check("rst_err",      128'(bus_a.err_resync), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, {4{4'hC, 4'(i)}}, 1'b1);
      @(negedge clk);
      check("rst_new_err", 128'(bus_a.err_resync), 128'd0);
    end
    check("rst_new_valid", 128'(bus_a.out_valid), 128'd1);
    check("rst_new_block", bus_a.out_block,       BR);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk);

    // Back-to-back blocks with in_valid held high.
    for (int j = 0; j < 12; j++) c6[j] = 32'h60000000 | (32'(j) * 32'h00010101);
    for (int b = 0; b < 3; b++) b6[b] = {c6[4*b], c6[4*b+1], c6[4*b+2], c6[4*b+3]};
    idx = 0; nblk = 0; cyc = 0; last_cyc = 0;
    while (nblk < 3 && cyc < 100) begin
      if (bus_a.out_valid) begin
        check($sformatf("b2b_block%0d", nblk), bus_a.out_block, b6[nblk]);
        if (nblk > 0) check("b2b_interval", 128'(cyc - last_cyc), 128'd5);
        last_cyc = cyc;
        nblk++;
      end
      if (idx < 12) begin
        drive(1'b1, (idx % 4) == 0, c6[idx], 1'b1);
        if (bus_a.in_ready) idx++;
      end else begin
        drive(1'b0, 1'b0, 32'h0, 1'b1);
      end
      @(negedge clk);
      cyc++;
    end
    check("b2b_blocks_seen", 128'(nblk), 128'd3);
    check("b2b_cols_taken",  128'(idx),  128'd12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
